// File: rtl/spi_sram_model_param.sv
// Clock-oversampled SPI-mode-0 model of a 23LCxxx serial SRAM with mode register,
// page/byte/sequential addressing and a backdoor port for preload and inspection.
module spi_sram_model_param #(
  parameter int unsigned MEM_DEPTH  = 4096,
  parameter int unsigned ADDR_BYTES = 2,
  parameter int unsigned PAGE_SIZE  = 32,
  parameter logic [1:0]  MODE_RST   = 2'b01
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sck,
  input  logic                         cs_n,
  input  logic                         si,
  output logic                         so,
  output logic                         so_oe,
  output logic [1:0]                   mode,
  output logic                         busy,
  input  logic                         bd_we,
  input  logic [$clog2(MEM_DEPTH)-1:0] bd_addr,
  input  logic [7:0]                   bd_wdata,
  output logic [7:0]                   bd_rdata
);
  localparam int unsigned   AW        = $clog2(MEM_DEPTH);
  localparam int unsigned   ADDR_BITS = ADDR_BYTES * 8;
  localparam logic [AW-1:0] PMASK     = AW'(PAGE_SIZE - 1);
  localparam logic [7:0]    OP_WRMR   = 8'h01;
  localparam logic [7:0]    OP_WRITE  = 8'h02;
  localparam logic [7:0]    OP_READ   = 8'h03;
  localparam logic [7:0]    OP_RDMR   = 8'h05;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_WR_DATA, ST_RD_DATA, ST_RDMR_DATA, ST_WRMR_DATA, ST_IGNORE
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [2:0]    r_sck_s, r_cs_s;
  logic [1:0]    r_si_s;
  logic [4:0]    r_bitcnt;
  logic [6:0]    r_cmd, r_wsh;
  logic [7:0]    r_shout;
  logic [AW-1:0] r_addr;
  logic [1:0]    r_mode;
  logic          r_is_read, r_one_done, r_so, r_so_oe;
  logic [7:0]    r_mem [MEM_DEPTH];

  logic          w_si, w_sck_rise, w_sck_fall, w_cs_rise, w_cs_fall;
  logic          w_bit7, w_addr_last, w_rd_stop, w_mem_we;
  logic [7:0]    w_cmd_byte, w_byte_in;
  logic [AW-1:0] w_addr_shift, w_addr_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sck_s <= '0;
      r_cs_s  <= '1;
      r_si_s  <= '0;
    end else begin
      r_sck_s <= {r_sck_s[1:0], sck};
      r_cs_s  <= {r_cs_s[1:0], cs_n};
      r_si_s  <= {r_si_s[0], si};
    end
  end

  assign w_si         = r_si_s[1];
  assign w_sck_rise   = r_sck_s[1] & ~r_sck_s[2];
  assign w_sck_fall   = ~r_sck_s[1] & r_sck_s[2];
  assign w_cs_rise    = r_cs_s[1] & ~r_cs_s[2];
  assign w_cs_fall    = ~r_cs_s[1] & r_cs_s[2];
  assign w_bit7       = (r_bitcnt == 5'd7);
  assign w_addr_last  = (r_bitcnt == 5'(ADDR_BITS - 1));
  assign w_cmd_byte   = {r_cmd, w_si};
  assign w_byte_in    = {r_wsh, w_si};
  // Only the low AW bits survive the shift, so high address bits drop out naturally.
  assign w_addr_shift = {r_addr[AW-2:0], w_si};
  assign w_addr_inc   = (r_mode == 2'b10) ? ((r_addr & ~PMASK) | ((r_addr + AW'(1)) & PMASK))
                                          : r_addr + AW'(1);
  assign w_rd_stop    = (r_state == ST_RD_DATA) && r_one_done && (r_mode == 2'b00) &&
                        (r_bitcnt == 5'd0);
  assign w_mem_we     = !w_cs_rise && (r_state == ST_WR_DATA) && w_sck_rise && w_bit7;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_cs_rise) begin
      w_state_nxt = ST_IDLE;
    end else if (w_cs_fall) begin
      w_state_nxt = ST_CMD;
    end else begin
      case (r_state)
        ST_CMD:
          if (w_sck_rise && w_bit7) begin
            case (w_cmd_byte)
              OP_READ, OP_WRITE: w_state_nxt = ST_ADDR;
              OP_RDMR:           w_state_nxt = ST_RDMR_DATA;
              OP_WRMR:           w_state_nxt = ST_WRMR_DATA;
              default:           w_state_nxt = ST_IGNORE;
            endcase
          end
        ST_ADDR:
          if (w_sck_rise && w_addr_last) w_state_nxt = r_is_read ? ST_RD_DATA : ST_WR_DATA;
        ST_WR_DATA:
          if (w_sck_rise && w_bit7 && (r_mode == 2'b00)) w_state_nxt = ST_IGNORE;
        ST_RD_DATA:
          if (w_sck_fall && w_rd_stop) w_state_nxt = ST_IGNORE;
        ST_WRMR_DATA:
          if (w_sck_rise && w_bit7) w_state_nxt = ST_IGNORE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bitcnt   <= '0;
      r_cmd      <= '0;
      r_wsh      <= '0;
      r_shout    <= '0;
      r_addr     <= '0;
      r_mode     <= MODE_RST;
      r_is_read  <= 1'b0;
      r_one_done <= 1'b0;
      r_so       <= 1'b0;
      r_so_oe    <= 1'b0;
    end else if (w_cs_rise) begin
      r_so    <= 1'b0;
      r_so_oe <= 1'b0;
    end else if (w_cs_fall) begin
      r_bitcnt   <= '0;
      r_one_done <= 1'b0;
    end else begin
      case (r_state)
        ST_CMD:
          if (w_sck_rise) begin
            r_cmd <= w_cmd_byte[6:0];
            if (w_bit7) begin
              r_bitcnt  <= '0;
              r_is_read <= (w_cmd_byte == OP_READ);
              r_shout   <= {r_mode, 6'b0};
            end else begin
              r_bitcnt <= r_bitcnt + 5'd1;
            end
          end
        ST_ADDR:
          if (w_sck_rise) begin
            r_addr <= w_addr_shift;
            if (w_addr_last) begin
              r_bitcnt <= '0;
              r_shout  <= r_mem[w_addr_shift];
            end else begin
              r_bitcnt <= r_bitcnt + 5'd1;
            end
          end
        ST_WR_DATA, ST_WRMR_DATA:
          if (w_sck_rise) begin
            r_wsh <= w_byte_in[6:0];
            if (w_bit7) begin
              r_bitcnt <= '0;
              if (r_state == ST_WR_DATA) r_addr <= w_addr_inc;
              else                       r_mode <= w_byte_in[7:6];
            end else begin
              r_bitcnt <= r_bitcnt + 5'd1;
            end
          end
        ST_RD_DATA, ST_RDMR_DATA:
          if (w_sck_fall) begin
            if (w_rd_stop) begin
              r_so    <= 1'b0;
              r_so_oe <= 1'b0;
            end else begin
              r_so    <= r_shout[7];
              r_so_oe <= 1'b1;
              if (w_bit7) begin
                // Next byte is fetched on the fall that emits bit 0, ready for the following fall.
                r_bitcnt   <= '0;
                r_one_done <= 1'b1;
                if (r_state == ST_RD_DATA) begin
                  r_addr  <= w_addr_inc;
                  r_shout <= r_mem[w_addr_inc];
                end else begin
                  r_shout <= {r_mode, 6'b0};
                end
              end else begin
                r_shout  <= {r_shout[6:0], 1'b0};
                r_bitcnt <= r_bitcnt + 5'd1;
              end
            end
          end
        default: begin
          r_so    <= 1'b0;
          r_so_oe <= 1'b0;
        end
      endcase
    end
  end

  // SPI write is issued last so it overrides a same-address backdoor write.
  always_ff @(posedge clk) begin
    if (bd_we)    r_mem[bd_addr] <= bd_wdata;
    if (w_mem_we) r_mem[r_addr]  <= w_byte_in;
  end

  assign so       = r_so & r_so_oe;
  assign so_oe    = r_so_oe;
  assign mode     = r_mode;
  assign busy     = ~r_cs_s[1] & (r_state != ST_IDLE);
  assign bd_rdata = r_mem[bd_addr];

endmodule

// File: tb/tb_spi_sram_model_param.sv
// Directed bench for spi_sram_model_param: SPI master tasks, backdoor checks and a
// queue of expected read bytes popped as each byte arrives on so.
module tb_spi_sram_model_param;
  localparam int HALF = 50;

  logic        clk = 1'b0;
  logic        rst_n, sck, cs_n, si;
  logic        so, so_oe, busy;
  logic [1:0]  mode;
  logic        bd_we;
  logic [11:0] bd_addr;
  logic [7:0]  bd_wdata, bd_rdata;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [7:0]  sb_q[$];
  logic [7:0]  rx;
  logic        oe_all, oe_any;

  spi_sram_model_param #(
    .MEM_DEPTH (4096),
    .ADDR_BYTES(2),
    .PAGE_SIZE (32),
    .MODE_RST  (2'b01)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sck     (sck),
    .cs_n    (cs_n),
    .si      (si),
    .so      (so),
    .so_oe   (so_oe),
    .mode    (mode),
    .busy    (busy),
    .bd_we   (bd_we),
    .bd_addr (bd_addr),
    .bd_wdata(bd_wdata),
    .bd_rdata(bd_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic [7:0] tx, input int unsigned nb,
                      output logic [7:0] r, output logic all_oe, output logic any_oe);
    r = '0; all_oe = 1'b1; any_oe = 1'b0;
    for (int unsigned i = 0; i < nb; i++) begin
      si = tx[7-i];
      #HALF;
      r = {r[6:0], so};
      all_oe &= so_oe;
      any_oe |= so_oe;
      sck = 1'b1;
      #HALF;
      sck = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] tx);
    logic [7:0] r;
    logic a, b;
    xfer(tx, 8, r, a, b);
  endtask

  task automatic cs_lo();
    cs_n = 1'b0;
    #(2*HALF);
  endtask

  task automatic cs_hi();
    #(2*HALF);
    cs_n = 1'b1;
    #(4*HALF);
  endtask

  task automatic bd_write(input logic [11:0] a, input logic [7:0] d);
    bd_addr = a; bd_wdata = d; bd_we = 1'b1;
    @(posedge clk);
    #1 bd_we = 1'b0;
  endtask

  task automatic bd_check(input string tag, input logic [11:0] a, input logic [7:0] d);
    bd_addr = a;
    #1;
    check(tag, bd_rdata, d);
  endtask

  task automatic read_bytes(input string tag, input int unsigned n);
    logic [7:0] r, e;
    logic a, b;
    for (int unsigned k = 0; k < n; k++) begin
      xfer(8'h00, 8, r, a, b);
      if (sb_q.size() == 0) begin
        check({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check(tag, r, e);
        check({tag, "_oe"}, a, 1'b1);
      end
    end
  endtask

  task automatic wrmr(input logic [7:0] v);
    cs_lo(); send(8'h01); send(v); cs_hi();
  endtask

  initial begin
    rst_n = 1'b0; sck = 1'b0; cs_n = 1'b1; si = 1'b0;
    bd_we = 1'b0; bd_addr = '0; bd_wdata = '0;
    #46;
    check("rst_so", so, 1'b0);
    check("rst_so_oe", so_oe, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_mode", mode, 2'b01);
    rst_n = 1'b1;
    #100;
    bd_write(12'h020, 8'hEE);
    bd_write(12'h101, 8'h99);
    bd_write(12'h040, 8'h3C);

    // Sequential write then read-back
    cs_lo(); send(8'h02);
    check("busy_frame", busy, 1'b1);
    send(8'h00); send(8'h10); send(8'hA5); send(8'h5A); send(8'hC3); cs_hi();
    bd_check("seq_w10", 12'h010, 8'hA5);
    bd_check("seq_w11", 12'h011, 8'h5A);
    bd_check("seq_w12", 12'h012, 8'hC3);
    cs_lo(); send(8'h03); send(8'h00);
    xfer(8'h10, 8, rx, oe_all, oe_any);
    check("oe_during_addr", oe_any, 1'b0);
    check("oe_before_fall_sync", so_oe, 1'b0);
    sb_q.push_back(8'hA5); sb_q.push_back(8'h5A); sb_q.push_back(8'hC3);
    read_bytes("seq_rd", 3);
    cs_hi();
    check("oe_after_cs", so_oe, 1'b0);

    // Page mode wrap
    wrmr(8'h80);
    check("mode_page", mode, 2'b10);
    cs_lo(); send(8'h02); send(8'h00); send(8'h1F); send(8'h11); send(8'h22); cs_hi();
    bd_check("pg_w1f", 12'h01F, 8'h11);
    bd_check("pg_w00", 12'h000, 8'h22);
    bd_check("pg_w20", 12'h020, 8'hEE);
    cs_lo(); send(8'h05);
    sb_q.push_back(8'h80); sb_q.push_back(8'h80);
    read_bytes("rdmr", 2);
    cs_hi();

    // Byte mode
    wrmr(8'h00);
    check("mode_byte", mode, 2'b00);
    cs_lo(); send(8'h02); send(8'h01); send(8'h00); send(8'h77); send(8'h88); cs_hi();
    bd_check("by_w100", 12'h100, 8'h77);
    bd_check("by_w101", 12'h101, 8'h99);
    cs_lo(); send(8'h03); send(8'h01); send(8'h00);
    sb_q.push_back(8'h77);
    read_bytes("by_rd", 1);
    xfer(8'h00, 8, rx, oe_all, oe_any);
    check("by_oe_off", oe_any, 1'b0);
    check("by_so_zero", rx, 8'h00);
    cs_hi();

    // Depth wrap with high address bits set
    wrmr(8'h40);
    check("mode_seq", mode, 2'b01);
    bd_write(12'hFFF, 8'hAB);
    bd_write(12'h000, 8'hCD);
    cs_lo(); send(8'h03); send(8'hFF); send(8'hFF);
    sb_q.push_back(8'hAB); sb_q.push_back(8'hCD);
    read_bytes("wrap_rd", 2);
    cs_hi();

    // Aborted partial write and unknown opcode
    cs_lo(); send(8'h02); send(8'h00); send(8'h40);
    xfer(8'hFF, 5, rx, oe_all, oe_any);
    cs_hi();
    bd_check("abort_w40", 12'h040, 8'h3C);
    check("abort_busy", busy, 1'b0);
    cs_lo();
    for (int k = 0; k < 4; k++) begin
      xfer((k == 0) ? 8'h9F : 8'h00, 8, rx, oe_all, oe_any);
      check("ign_oe", oe_any, 1'b0);
    end
    check("ign_busy", busy, 1'b1);
    cs_hi();

    // Reset in the middle of a read
    wrmr(8'h80);
    check("mode_page2", mode, 2'b10);
    cs_lo(); send(8'h03); send(8'h00); send(8'h10);
    sb_q.push_back(8'hA5);
    read_bytes("pre_rst", 1);
    xfer(8'h00, 4, rx, oe_all, oe_any);
    check("mid_oe", oe_all, 1'b1);
    rst_n = 1'b0;
    #20;
    check("mrst_so", so, 1'b0);
    check("mrst_so_oe", so_oe, 1'b0);
    check("mrst_mode", mode, 2'b01);
    check("mrst_busy", busy, 1'b0);
    cs_n = 1'b1;
    #100;
    rst_n = 1'b1;
    #200;
    cs_lo(); send(8'h03); send(8'h00); send(8'h10);
    sb_q.push_back(8'hA5); sb_q.push_back(8'h5A);
    read_bytes("post_rst", 2);
    cs_hi();
    check("sb_drained", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_sram_model_param.md
Name: spi_sram_model_param

Overview:
Parametrised, clock-oversampled model of a 23LCxxx-class SPI serial SRAM, used as the off-chip memory for the TinyTO serv core in benches and FPGA bring-up. It generalises the fixed 16-bit-address, READ/WRITE-only model. It adds configurable depth and address width, the 23LC mode register (byte, page and sequential modes), RDMR/WRMR commands and page wrap. It also adds a backdoor port so benches can preload and check memory. SPI mode 0 only; sck, cs_n and si are synchronised into clk.

Parameters:
MEM_DEPTH, 4096, number of bytes; power of two; AW = clog2(MEM_DEPTH)
ADDR_BYTES, 2, address bytes after command (2 = 23LC512, 3 = 23LC1024)
PAGE_SIZE, 32, page-mode wrap size in bytes; power of two; ≤ MEM_DEPTH; PW = clog2(PAGE_SIZE)
MODE_RST, 2'b01, mode register reset value (01 = sequential)

Ports:
clk  in  1  system clock; must be ≥ 4x the sck frequency
rst_n  in  1  asynchronous, active-low reset
sck  in  1  SPI clock, idle low
cs_n  in  1  chip select, active low
si  in  1  serial data in (MOSI)
so  out  1  serial data out (MISO)
so_oe  out  1  high while the model drives read data
mode  out  2  current mode register bits [7:6]
busy  out  1  high while cs_n_sync is low and state ≠ IDLE
bd_we  in  1  backdoor write strobe
bd_addr  in  AW  backdoor address
bd_wdata  in  8  backdoor write data
bd_rdata  out  8  combinational backdoor read, mem[bd_addr]

Behaviour:
- Reset: rst_n is asynchronous and active-low; clk is the single clock.
  - State = IDLE; so = 0; so_oe = 0; busy = 0; mode = MODE_RST; synchronisers = idle (sck 0, cs_n 1).
  - Memory contents are not cleared.
- Input sync: two-flop synchronisers on sck, cs_n and si.
  - sck_rise and sck_fall are single-clk pulses from the synchronised sck.
  - Every action below is taken on the clk edge at which the pulse is seen.
- Framing: falling cs_n_sync resets the bit counter. Rising cs_n_sync from any state gives:
  - state → IDLE; so_oe = 0; so = 0;
  - any partial write byte is discarded; the memory is unchanged.
- Bit order and edges: MSB first. si is sampled on sck_rise. so is updated on sck_fall.
- States: IDLE → CMD (8 bits) → ADDR (ADDR_BYTES*8 bits) → WR_DATA or RD_DATA.
  - From CMD, RDMR and WRMR go directly to RDMR_DATA or WRMR_DATA.
  - Any state can move to IGNORE.
- Commands:
  - 0x03 READ, 0x02 WRITE, 0x05 RDMR, 0x01 WRMR.
  - Any other opcode goes to IGNORE until cs_n rises. so_oe stays 0 in IGNORE.
- Address: the full ADDR_BYTES*8 bits are shifted in. Only the low AW bits are used; upper bits are ignored, so the address wraps modulo MEM_DEPTH.
- READ:
  - On the sck_rise of the last address bit, load shift_out = mem[addr].
  - On the next sck_fall: so = bit7, so_oe = 1.
  - Each later sck_fall shifts the next bit out.
  - After 8 bits the address advances per mode and the next byte is loaded.
- WRITE:
  - 8 bits are collected into a shift register.
  - On the 8th sck_rise, mem[addr] ← byte, then the address advances per mode.
- Address advance by mode:
  - Sequential (01, and reserved 11): addr+1 mod MEM_DEPTH.
  - Page (10): {addr[AW-1:PW], addr[PW-1:0]+1}, i.e. wraps within the page.
  - Byte (00): after one byte, go to IGNORE; so_oe = 0; further writes are not stored.
- WRMR:
  - The first data byte sets mode = byte[7:6]. The new mode applies from the next cs_n frame.
  - Then go to IGNORE.
- RDMR:
  - Outputs {mode, 6'b0}, with the same so timing as READ.
  - The byte repeats while clocked.
- Backdoor:
  - bd_we writes mem[bd_addr] on clk.
  - If it hits the same address as an SPI write in the same cycle, the SPI write wins.
  - bd_rdata reflects SPI writes one clk later.
- so is 0 whenever so_oe = 0.
- rst_n asserted mid-frame aborts the frame the same way cs_n rising does, and also resets mode.

Test Plan:
1. Sequential default: WRITE 0x02, addr 0x0010, data A5 5A C3 → backdoor reads 0x10=A5, 0x11=5A, 0x12=C3. Then READ 0x03, addr 0x0010, 24 clocks → so returns A5 5A C3; so_oe rises on the sck_fall after the last address bit.
2. Page wrap: WRMR 0x80; then WRITE at 0x001F with 11 22 → 0x1F=11, 0x00=22, and 0x20 is unchanged. RDMR → 0x80.
3. Byte mode: WRMR 0x00; WRITE at 0x0100 with 77 88 → 0x100=77, 0x101 unchanged. READ at 0x0100 for 16 clocks → 77, then so_oe=0.
4. Depth wrap and high address bits: MEM_DEPTH=4096, sequential; READ at 0xFFFF after preloading 0xFFF=0xAB and 0x000=0xCD → returns AB CD.
5. Abort: WRITE at 0x0040 with 5 bits, then cs_n high → 0x40 unchanged, busy=0. Opcode 0x9F → so_oe stays 0 for 32 clocks.
6. Reset mid-READ: pulse rst_n low → so=0, so_oe=0, mode=01; memory preserved, so a fresh READ returns the pre-reset data.
